// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM-like 2:1 arbiter: request source IDs and
// access-size codes of the SRAM-like bus.
package sram_arbiter_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_id_fifo.sv
// DEPTH-entry FIFO of 1-bit source IDs; remembers which CPU port issued each
// outstanding mem request so responses can be routed back in order.
module sram_id_fifo
    import sram_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  src_e push_src,
    input  logic pop,
    output logic full,
    output logic empty,
    output src_e head
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);

    src_e             mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {(PTR_W + 1){1'b0}});
    assign head      = mem_r[head_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {(PTR_W + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= SRC_INST;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[tail_r] <= push_src;
                tail_r        <= tail_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                head_r <= head_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// 2:1 SRAM-like arbiter merging the CPU instruction and data ports onto one
// mem port; data wins ties, and a presented-but-unaccepted request is locked.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    src_e lock_src_r;
    logic lock_r;
    src_e sel_s;
    logic sel_req_s;
    logic fifo_full_s;
    logic fifo_empty_s;
    src_e fifo_head_s;
    logic resp_s;

    // Source selection: a locked port keeps the grant; otherwise data wins.
    always_comb begin
        sel_s = SRC_INST;
        if (lock_r) begin
            sel_s = lock_src_r;
        end else if (data_sram_req) begin
            sel_s = SRC_DATA;
        end else begin
            sel_s = SRC_INST;
        end
    end

    // Request field mux toward the memory side.
    always_comb begin
        sel_req_s = inst_sram_req;
        mem_wr    = inst_sram_wr;
        mem_size  = inst_sram_size;
        mem_wstrb = inst_sram_wstrb;
        mem_addr  = inst_sram_addr;
        mem_wdata = inst_sram_wdata;
        if (sel_s == SRC_DATA) begin
            sel_req_s = data_sram_req;
            mem_wr    = data_sram_wr;
            mem_size  = data_sram_size;
            mem_wstrb = data_sram_wstrb;
            mem_addr  = data_sram_addr;
            mem_wdata = data_sram_wdata;
        end else begin
            sel_req_s = inst_sram_req;
        end
    end

    assign mem_req           = sel_req_s && !fifo_full_s && !reset;
    assign inst_sram_addr_ok = mem_addr_ok && mem_req && (sel_s == SRC_INST);
    assign data_sram_addr_ok = mem_addr_ok && mem_req && (sel_s == SRC_DATA);

    // Responses with nothing outstanding (e.g. after a reset) are dropped.
    assign resp_s            = mem_data_ok && !fifo_empty_s && !reset;
    assign inst_sram_data_ok = resp_s && (fifo_head_s == SRC_INST);
    assign data_sram_data_ok = resp_s && (fifo_head_s == SRC_DATA);
    assign inst_sram_rdata   = mem_rdata;
    assign data_sram_rdata   = mem_rdata;

    // Lock holds mem_* stable until the slave accepts the presented request.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_r     <= 1'b0;
            lock_src_r <= SRC_INST;
        end else if (mem_req && mem_addr_ok) begin
            lock_r     <= 1'b0;
            lock_src_r <= lock_src_r;
        end else if (mem_req) begin
            lock_r     <= 1'b1;
            lock_src_r <= sel_s;
        end else begin
            lock_r     <= lock_r;
            lock_src_r <= lock_src_r;
        end
    end

    sram_id_fifo #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (mem_req && mem_addr_ok),
        .push_src(sel_s),
        .pop     (mem_data_ok),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .head    (fifo_head_s)
    );

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- 2:1 arbiter that sits directly downstream of the CPU top.
- Merges the CPU's instruction and data SRAM-like master interfaces into one SRAM-like master port toward the memory side (bridge or RAM wrapper).
- Tracks the source of every outstanding request so that responses (data_ok, rdata) return to the correct CPU port, in order.

Parameters:
- DEPTH, 4: max outstanding requests on the mem port; power of 2, ≥2.
- PTR_W, 2: log2(DEPTH).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_sram_req  in  1  instruction request valid
inst_sram_wr  in  1  1=write
inst_sram_size  in  2  0/1/2 = byte/half/word
inst_sram_wstrb  in  4  byte write strobes
inst_sram_addr  in  32  request address
inst_sram_wdata  in  32  write data
inst_sram_addr_ok  out  1  instruction request accepted
inst_sram_data_ok  out  1  instruction response valid
inst_sram_rdata  out  32  instruction read data
data_sram_req  in  1  data request valid
data_sram_wr  in  1  1=write
data_sram_size  in  2  access size
data_sram_wstrb  in  4  byte write strobes
data_sram_addr  in  32  request address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  data request accepted
data_sram_data_ok  out  1  data response valid
data_sram_rdata  out  32  data read data
mem_req  out  1  merged request valid
mem_wr  out  1  merged write flag
mem_size  out  2  merged size
mem_wstrb  out  4  merged strobes
mem_addr  out  32  merged address
mem_wdata  out  32  merged write data
mem_addr_ok  in  1  mem accepted request
mem_data_ok  in  1  mem response valid, in request order
mem_rdata  in  32  mem read data

Behaviour:
- Clock and reset: one clock clk; reset synchronous, active-high, named reset.
- Handshake: a request transfers on a cycle with req && addr_ok; a response transfers on a cycle with data_ok; both are single-cycle.
- Arbitration source (sel: SRC_INST=0, SRC_DATA=1):
  - If lock=1, sel = lock_src.
  - Otherwise data wins when both requests are high; else the requesting port is selected.
- Lock register: set to (1, sel) when mem_req && !mem_addr_ok; cleared on mem_addr_ok. This keeps mem_* stable until acceptance, as the SRAM-like protocol requires.
- Merged port:
  - mem_req = (sel port req) && !full && !reset.
  - mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata are muxed combinationally from the sel port.
- Acceptance:
  - inst_sram_addr_ok = mem_addr_ok && mem_req && sel==INST.
  - data_sram_addr_ok = mem_addr_ok && mem_req && sel==DATA.
  - The unselected port's addr_ok is 0.
- Source FIFO: DEPTH x 1 bit, with head/tail pointers of PTR_W bits (wrap modulo DEPTH) and a count of PTR_W+1 bits.
  - Push sel on mem_req && mem_addr_ok.
  - Pop on mem_data_ok && count!=0.
  - Simultaneous push and pop: count unchanged; both pointers advance.
- Full (count==DEPTH): mem_req forced 0 and lock held; no push.
- Empty: mem_data_ok is ignored; both data_ok outputs stay 0.
- Response routing:
  - inst_sram_data_ok = mem_data_ok && count!=0 && head==INST; data_sram_data_ok likewise for DATA.
  - Both rdata outputs equal mem_rdata.
  - Write requests also receive data_ok.
- Slave guarantee: mem_data_ok never occurs in the same cycle as the addr_ok of the same request. No bypass path exists.
- Reset and reset values:
  - During reset, all addr_ok, data_ok and mem_req outputs are 0.
  - Next cycle: count=0, head=tail=0, lock=0.
  - Reset mid-operation drops all outstanding entries; late mem_data_ok is then discarded as in the empty case.
- Latency: zero added cycles on both request and response paths (fully combinational pass-through).

Decomposition:
- Shared package: SRC_INST/SRC_DATA encodings; SRAM-like size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
- One sub-module, sram_id_fifo: parameterised DEPTH-entry 1-bit FIFO with push/pop/full/empty/head outputs.

Test Plan:
- Simultaneous requests: inst req addr 0x1c000000 and data read 0x00001000 in the same cycle, mem_addr_ok=1 → data granted first, inst next cycle; responses 0xAAAA0000 then 0xBBBB0000 → data_sram_data_ok with 0xAAAA0000, then inst_sram_data_ok with 0xBBBB0000.
- Lock: inst req with mem_addr_ok=0 for 3 cycles; data req arrives in cycle 2 → mem_addr stays 0x1c000000 until acceptance, then data is granted.
- Full: 4 inst reads accepted with no data_ok → count=4, mem_req=0 on the 5th req; one mem_data_ok → 5th request accepted the next cycle.
- Push/pop same cycle: count=2, accept a new request and return a response in one cycle → count stays 2; routing order is preserved across pointer wrap after 6+ transactions.
- Reset: reset with 3 outstanding requests → count=0; a stray mem_data_ok afterwards produces no data_ok on either port.
- Write: data write addr 0x10, wstrb 4'b0011, size=1 → mem_wr=1 with fields passed through; the returning data_ok is routed to data_sram_data_ok.
